mult_div_unit: RTL and testbench

- Iterative multiply/divide unit (MIPS MULT/MULTU/DIV/DIVU) sitting directly downstream of the register file.
- Consumes the two register read values (rs, rt) as operands.
- Holds the architectural HI/LO registers that later feed MFHI/MFLO into the write-back mux.
- Fixed-latency, one operation in flight, start/busy/done handshake toward the control unit.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_if.sv | 41 ++++
 rtl/mdu_iter_core.sv | 34 +++
 rtl/mult_div_unit.sv | 160 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: opcodes, FSM states, iteration counter width.
// Optional MTHI/MTLO write port is enabled by defining MDU_HILO_WRITE_EN.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  // Wide enough to count DATA_W iterations for any DATA_W up to 64.
  localparam int MDU_CNT_W = 6;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Control-unit <-> MDU bundle: start/op/operands in, busy/done/flags/HI/LO out.
// Carries hilo_we/hilo_wdata only when MDU_HILO_WRITE_EN is defined.
interface mdu_if #(
  parameter int DATA_W = 32
);

  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
`ifdef MDU_HILO_WRITE_EN
  logic [1:0]        hilo_we;
  logic [DATA_W-1:0] hilo_wdata;

  modport master (
    output start, op, operand_a, operand_b, hilo_we, hilo_wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, hilo_we, hilo_wdata,
    output busy, done, div_by_zero, hi, lo
  );
`else
  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, div_by_zero, hi, lo
  );
`endif

endinterface

// File: rtl/mdu_iter_core.sv
// One combinational iteration: shift-add multiply step or restoring-divide step on {upper, lower}.
// Multiply: lower holds the multiplier, operand the multiplicand. Divide: lower holds the dividend/quotient.
module mdu_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic              is_div_i,
  input  logic [DATA_W-1:0] upper_i,
  input  logic [DATA_W-1:0] lower_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic [DATA_W-1:0] upper_o,
  output logic [DATA_W-1:0] lower_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] rem_sub;
  logic              fits;

  always_comb begin
    sum     = {1'b0, upper_i} + (lower_i[0] ? {1'b0, operand_i} : '0);
    shifted = {upper_i, lower_i[DATA_W-1]};
    fits    = (shifted >= {1'b0, operand_i});
    // When the divisor fits, the true difference is below 2^DATA_W, so a narrow subtract is exact.
    rem_sub = shifted[DATA_W-1:0] - operand_i;

    upper_o = sum[DATA_W:1];
    lower_o = {sum[0], lower_i[DATA_W-1:1]};
    if (is_div_i) begin
      upper_o = fits ? rem_sub : shifted[DATA_W-1:0];
      lower_o = {lower_i[DATA_W-2:0], fits};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; result 33 clocks after the start edge.
// Define MDU_HILO_WRITE_EN to add the MTHI/MTLO write port.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  mdu_state_e            state_q, state_d;
  logic [MDU_CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]     upper_q, upper_d;
  logic [DATA_W-1:0]     lower_q, lower_d;
  logic [DATA_W-1:0]     opnd_q, opnd_d;
  logic                  is_div_q, is_div_d;
  logic                  neg_q, neg_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  dbz_q, dbz_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic                  done_q, done_d;
  logic                  dbz_out_q, dbz_out_d;

  logic [DATA_W-1:0]     step_upper, step_lower;
  logic                  start_div, start_signed;
  logic                  sign_a, sign_b;
  logic [DATA_W-1:0]     mag_a, mag_b;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quo_fix, rem_fix;

  mdu_iter_core #(.DATA_W(DATA_W)) u_core (
    .is_div_i (is_div_q),
    .upper_i  (upper_q),
    .lower_i  (lower_q),
    .operand_i(opnd_q),
    .upper_o  (step_upper),
    .lower_o  (step_lower)
  );

  always_comb begin : operand_prep
    start_div    = op_is_div(bus.op);
    start_signed = op_is_signed(bus.op);
    sign_a       = start_signed & bus.operand_a[DATA_W-1];
    sign_b       = start_signed & bus.operand_b[DATA_W-1];
    mag_a        = sign_a ? -bus.operand_a : bus.operand_a;
    mag_b        = sign_b ? -bus.operand_b : bus.operand_b;
  end

  always_comb begin : sign_fixup
    prod_fix = neg_q ? -{upper_q, lower_q} : {upper_q, lower_q};
    quo_fix  = neg_q ? -lower_q : lower_q;
    rem_fix  = neg_rem_q ? -upper_q : upper_q;
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    cnt_d     = cnt_q;
    upper_d   = upper_q;
    lower_d   = lower_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;

`ifdef MDU_HILO_WRITE_EN
    // Software writes come first so that a result landing on the same edge overrides them.
    if (bus.hilo_we[1]) hi_d = bus.hilo_wdata;
    if (bus.hilo_we[0]) lo_d = bus.hilo_wdata;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          upper_d   = '0;
          lower_d   = start_div ? mag_a : mag_b;
          opnd_d    = start_div ? mag_b : mag_a;
          is_div_d  = start_div;
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          dbz_d     = start_div && (bus.operand_b == '0);
        end
      end
      ST_RUN: begin
        upper_d = step_upper;
        lower_d = step_lower;
        if (cnt_q == MDU_CNT_W'(DATA_W - 1)) begin
          state_d = ST_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + MDU_CNT_W'(1);
        end
      end
      ST_FIX: begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        dbz_out_d = dbz_q;
        if (is_div_q) begin
          // A zero divisor leaves the dividend as remainder; only the quotient is forced.
          hi_d = rem_fix;
          lo_d = dbz_q ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      upper_q   <= '0;
      lower_q   <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      upper_q   <= upper_d;
      lower_q   <= lower_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_out_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: arithmetic reference model, queued expectations, decoupled monitor.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 33;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if #(.DATA_W(W)) bus ();
  mult_div_unit #(.DATA_W(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t         q[$];
  exp_t         e;
  int           checks    = 0;
  int           failures  = 0;
  int           cyc       = 0;
  int           last_edge = -1000;
  logic [W-1:0] m_hi      = '0;
  logic [W-1:0] m_lo      = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int edge_n);
    exp_t            r;
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r.dbz    = 1'b0;
    r.edge_n = edge_n;
    r.hi     = '0;
    r.lo     = '0;
    if ((op == OP_DIV || op == OP_DIVU) && b == 0) begin
      r.hi  = a;
      r.lo  = '1;
      r.dbz = 1'b1;
    end else begin
      case (op)
        OP_MULT:  begin sp = sa * sb; r.hi = sp[63:32]; r.lo = sp[31:0]; end
        OP_MULTU: begin up = ua * ub; r.hi = up[63:32]; r.lo = up[31:0]; end
        OP_DIV:   begin sp = sa / sb; r.lo = sp[31:0]; sp = sa % sb; r.hi = sp[31:0]; end
        default:  begin up = ua / ub; r.lo = up[31:0]; up = ua % ub; r.hi = up[31:0]; end
      endcase
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; the start is seen at the following posedge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    if (cyc + 1 >= last_edge + LAT + 1) begin
      last_edge = cyc + 1;
      q.push_back(model(op, a, b, cyc + 1));
    end
    @(negedge clk);
    bus.start     = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
  endtask

  task automatic wait_idle();
    while (cyc + 1 < last_edge + LAT + 1) @(negedge clk);
  endtask

  // Monitor: compares every cycle, popping the scoreboard on done.
  always begin
    @(posedge clk);
    #1;
    check("busy", W'(bus.busy), W'((cyc >= last_edge) && (cyc <= last_edge + LAT - 1)));
    if (bus.done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done cycle=%0d actual=1 expected=0", cyc);
      end else begin
        e = q.pop_front();
        check("latency", W'(cyc - e.edge_n), W'(LAT));
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
        check("div_by_zero", W'(bus.div_by_zero), W'(e.dbz));
        m_hi = e.hi;
        m_lo = e.lo;
      end
    end else begin
      check("dbz_idle", W'(bus.div_by_zero), '0);
      check("hi_hold", bus.hi, m_hi);
      check("lo_hold", bus.lo, m_lo);
      if (q.size() != 0 && cyc > q[0].edge_n + LAT) begin
        checks++;
        failures++;
        $display("FAIL missing_done cycle=%0d actual=0 expected=1", cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [1:0] rop;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = OP_MULT;
    bus.operand_a = '0;
    bus.operand_b = '0;
`ifdef MDU_HILO_WRITE_EN
    bus.hilo_we    = '0;
    bus.hilo_wdata = '0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_hi", bus.hi, '0);
    check("rst_lo", bus.lo, '0);
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    @(negedge clk);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    issue(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005); wait_idle();
    issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002); wait_idle();
    issue(OP_DIVU,  32'hFFFF_FFF9, 32'h0000_0002); wait_idle();
    issue(OP_DIVU,  32'h1234_5678, 32'h0000_0000); wait_idle();
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000); wait_idle();

    // Second start while busy must be dropped.
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    issue(OP_MULTU, 32'd9, 32'd11);
    wait_idle();
    issue(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000);   // lands in the done cycle
    wait_idle();
    repeat (2) @(negedge clk);

    // Reset mid-operation discards it.
    issue(OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (8) @(negedge clk);
    reset     = 1'b1;
    last_edge = -1000;
    q.delete();
    m_hi      = '0;
    m_lo      = '0;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_hi", bus.hi, '0);
    check("midrst_lo", bus.lo, '0);
    check("midrst_busy", W'(bus.busy), '0);
    check("midrst_done", W'(bus.done), '0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end else begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end
      issue(rop, pick(), pick());
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_drained", W'(q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
